dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port byte-lane data memory. It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port) using round-robin. It converts byte/half/word requests into word-aligned byte-enable accesses and returns zero-extended, little-endian read data. Optionally, it splits misaligned accesses into two memory accesses.

## Interface
- No parameters; two requesters fixed, 32-bit address/data.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high.
- pN_req  in  1  requester N (N=0,1) has a request pending; fields below held stable until pN_gnt
- pN_we  in  1  1=store, 0=load
- pN_addr  in  32  byte address
- pN_size  in  2  00 byte, 01 half, 10 word; 11 illegal
- pN_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- pN_gnt  out  1  request accepted this cycle (combinational, IDLE only)
- pN_rvalid  out  1  one-cycle completion pulse (loads and stores)
- pN_rdata  out  32  load data, zero-extended; 0 for stores/errors; valid with rvalid
- pN_err  out  1  error completion, valid with rvalid
- mem_addr  out  32  word-aligned address (addr & ~3)
- mem_wdata  out  32  lane k = [8k+7:8k] written to byte mem_addr+k
- mem_wbyte  out  4  per-lane write enable
- mem_wr_en  out  1  write strobe
- mem_rd_en  out  1  read strobe
- mem_rdata  in  32  lane k = byte mem_addr+k, combinational from mem_addr

## Operation
- FSM: IDLE, ACC1, ACC2, RESP.
- IDLE: if any req, grant exactly one; capture owner, we, addr, size, wdata; go ACC1. Otherwise stay.
- Round-robin: last_owner register. On conflict, grant the port that is not last_owner. Reset last_owner=1 (p0 wins first conflict). Updated on every grant.
- Offset o=addr[1:0], bytes n=1/2/4. Lanes o..o+n-1 in first word. Store data byte i goes to lane o+i.
- Misaligned: o+n>4. size=11 is illegal regardless.
- ACC1: drive mem_addr=base, mem_rd_en=~we, mem_wr_en=we, mem_wbyte = lanes o..min(o+n-1,3). Capture mem_rdata lanes into result bytes 0.. at clock edge.
  - Next state: ACC2 if misaligned (macro on), else RESP.
- ACC2: mem_addr=base+4, lanes 0..o+n-5. Store bytes continue from byte 4-o. Read lanes fill remaining result bytes. Next RESP.
- RESP: pulse owner's rvalid with rdata/err, then IDLE. Non-owner rvalid stays 0.
- Illegal size or disabled misaligned: skip memory entirely, IDLE->RESP with err=1, rdata=0.
- Memory strobes and mem_wbyte are 0 outside ACC1/ACC2. mem_addr and mem_wdata are don't-care then, but driven to 0.
- Address arithmetic is 32-bit; base+4 wraps 0xFFFFFFFC->0x00000000.

## Timing
- Reset values:
  - state=IDLE, last_owner=1.
  - All pN_gnt/rvalid/err=0, pN_rdata=0.
  - mem_* outputs=0.
- Grant at cycle T. Aligned: memory access T+1, rvalid T+2. Misaligned split: accesses T+1,T+2, rvalid T+3. Error: rvalid T+1.
- No grant in ACC1/ACC2/RESP. Earliest next grant is the cycle after RESP (peak: one aligned op per 3 cycles).
- Requester must keep req/fields stable until gnt. Dropping req before gnt withdraws it without effect.
- Requester may reassert req in its RESP cycle; the request is considered in the following IDLE.
- Reset mid-operation: abort at next edge, no rvalid. A partially written split store leaves the first word written.

## Configuration
- DMEM_ARB_MISALIGN_EN defined: misaligned half/word accesses are split into ACC1+ACC2 as above.
- Undefined: ACC2 is never entered. Misaligned requests complete with err=1, rdata=0, and zero memory strobes.

## Test plan
- Reset, then p0 word load addr 0x8, mem bytes 0x8..0xB = 11,22,33,44 -> p0_gnt T, mem_rd_en T+1 mem_addr 0x8, p0_rvalid T+2 rdata 0x44332211, err 0.
- p1 byte store addr 0x13 wdata 0xAB -> mem_addr 0x10, mem_wbyte 1000, mem_wdata[31:24]=0xAB, p1_rvalid T+2 rdata 0.
- p0 and p1 req every cycle after reset -> grants alternate p0,p1,p0,p1; never both gnt in one cycle.
- Half load addr 0x7, bytes 0x7=CD, 0x8=EF:
  - macro on: reads 0x4 lane3 then 0x8 lane0, rdata 0x0000EFCD at T+3.
  - macro off: err=1 at T+1, no strobes.
- size=11 store -> err=1, rvalid T+1, mem_wr_en never asserted. Reset asserted in ACC1 of a load -> no rvalid; first post-reset conflict grants p0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for dmem_arbiter: one instance per requester.
// master = requester (core LSU or debug/DMA), slave = arbiter.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and byte-lane sequencer for the single-port data memory.
// Define DMEM_ARB_MISALIGN_EN to split misaligned half/word accesses into two word accesses.
module dmem_arbiter (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wbyte,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    input  logic [31:0]   mem_rdata
);

`ifdef DMEM_ARB_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC1 = 2'b01,
        ST_ACC2 = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        logic mis;
        case (size)
            2'b01:   mis = (off == 2'b11);
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_owner_r;
    logic        owner_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic [31:0] wdata_r;
    logic [31:0] result_r;
    logic        err_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        any_gnt_s;
    logic        sel_owner_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_wdata_s;
    logic        sel_illegal_s;

    logic [31:0] base_addr_s;
    logic [31:0] size_mask32_s;
    logic [7:0]  lane_span_s;
    logic [63:0] store_span_s;
    logic [31:0] rd_lo_s;
    logic [31:0] rd_hi_s;
    logic        resp0_s;
    logic        resp1_s;

    // Grant decision: only in IDLE; on conflict the port that did not win last time wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (p0.req && p1.req) begin
                if (last_owner_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (p0.req) begin
                gnt0_s = 1'b1;
            end else if (p1.req) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign any_gnt_s   = gnt0_s | gnt1_s;
    assign sel_owner_s = gnt1_s;
    assign sel_we_s    = gnt1_s ? p1.we    : p0.we;
    assign sel_addr_s  = gnt1_s ? p1.addr  : p0.addr;
    assign sel_size_s  = gnt1_s ? p1.size  : p0.size;
    assign sel_wdata_s = gnt1_s ? p1.wdata : p0.wdata;
    // Requests that cannot be served skip the memory and answer with an error.
    assign sel_illegal_s = (sel_size_s == 2'b11) ||
                           (is_misaligned(sel_addr_s[1:0], sel_size_s) && !MISALIGN_EN);

    // Lane bookkeeping: the low nibble/word addresses the first memory word, the high one the next.
    assign base_addr_s   = {addr_r[31:2], 2'b00};
    assign size_mask32_s = lane_expand(size_mask(size_r));
    assign lane_span_s   = {4'b0000, size_mask(size_r)} << addr_r[1:0];
    assign store_span_s  = {32'h0000_0000, wdata_r & size_mask32_s} << {addr_r[1:0], 3'b000};
    assign rd_lo_s       = (mem_rdata >> {addr_r[1:0], 3'b000}) & size_mask32_s;
    assign rd_hi_s       = (mem_rdata << (6'd32 - {1'b0, addr_r[1:0], 3'b000})) & size_mask32_s;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_gnt_s) begin
                    state_nxt_s = sel_illegal_s ? ST_RESP : ST_ACC1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC1: begin
                if (MISALIGN_EN && is_misaligned(addr_r[1:0], size_r)) begin
                    state_nxt_s = ST_ACC2;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_ACC2: state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory port drive: active only in the two access states, all zero otherwise.
    always_comb begin
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wbyte = 4'b0000;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        case (state_r)
            ST_ACC1: begin
                mem_addr  = base_addr_s;
                mem_wdata = store_span_s[31:0];
                mem_wbyte = we_r ? lane_span_s[3:0] : 4'b0000;
                mem_wr_en = we_r;
                mem_rd_en = ~we_r;
            end
            ST_ACC2: begin
                mem_addr  = base_addr_s + 32'd4;
                mem_wdata = store_span_s[63:32];
                mem_wbyte = we_r ? lane_span_s[7:4] : 4'b0000;
                mem_wr_en = we_r;
                mem_rd_en = ~we_r;
            end
            default: begin
                mem_addr  = 32'h0000_0000;
                mem_wdata = 32'h0000_0000;
                mem_wbyte = 4'b0000;
                mem_wr_en = 1'b0;
                mem_rd_en = 1'b0;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_owner_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (any_gnt_s) begin
                last_owner_r <= sel_owner_s;
            end
        end
    end

    // Request capture at grant and read-data assembly across the access states.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r  <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= 32'h0000_0000;
            size_r   <= 2'b00;
            wdata_r  <= 32'h0000_0000;
            result_r <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else if (any_gnt_s) begin
            owner_r  <= sel_owner_s;
            we_r     <= sel_we_s;
            addr_r   <= sel_addr_s;
            size_r   <= sel_size_s;
            wdata_r  <= sel_wdata_s;
            result_r <= 32'h0000_0000;
            err_r    <= sel_illegal_s;
        end else if ((state_r == ST_ACC1) && !we_r) begin
            result_r <= rd_lo_s;
        end else if ((state_r == ST_ACC2) && !we_r) begin
            result_r <= result_r | rd_hi_s;
        end
    end

    assign resp0_s = (state_r == ST_RESP) && !owner_r;
    assign resp1_s = (state_r == ST_RESP) &&  owner_r;

    assign p0.gnt    = gnt0_s;
    assign p0.rvalid = resp0_s;
    assign p0.err    = resp0_s & err_r;
    assign p0.rdata  = (resp0_s && !we_r && !err_r) ? result_r : 32'h0000_0000;

    assign p1.gnt    = gnt1_s;
    assign p1.rvalid = resp1_s;
    assign p1.err    = resp1_s & err_r;
    assign p1.rdata  = (resp1_s && !we_r && !err_r) ? result_r : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbyte;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0        (p0_if.slave),
        .p1        (p1_if.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wbyte (mem_wbyte),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    // 256-byte memory indexed by address[7:0]; preload port used only while the DUT is idle.
    logic [7:0] mem    [0:255];
    logic [7:0] refmem [0:255];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    assign mem_rdata = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                        mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wbyte[k]) mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[8*k +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Observations of the last run_op call
    logic        obs_timeout;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_rd_cnt;
    int          obs_wr_cnt;
    logic        obs_other_rv;
    logic        obs_both_gnt;
    logic [31:0] acc1_addr, acc1_wdata, acc2_addr;
    logic        acc1_rd, acc1_wr, acc2_rd;
    logic [3:0]  acc1_wbyte;

    task automatic preload_byte(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        refmem[a] = d;
    endtask

    task automatic drive_port(input int port, input logic req, input logic we,
                              input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.size = size; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.size = size; p1_if.wdata = wdata;
        end
    endtask

    // Reference: byte-level semantics of one request; updates refmem for stores.
    task automatic ref_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, output logic [31:0] er,
                          output logic ee, output int el);
        int n;
        bit mis;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mis = (int'(addr[1:0]) + n) > 4;
        er  = 32'h0;
        if (size == 2'b11 || (mis && !MIS_EN)) begin
            ee = 1'b1; el = 1;
            return;
        end
        ee = 1'b0;
        el = mis ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = addr[7:0] + 8'(i);
            if (we) refmem[a] = wdata[8*i +: 8];
            else    er[8*i +: 8] = refmem[a];
        end
    endtask

    // Issue one request on a port and record grant/latency/strobe observations.
    task automatic run_op(input int port, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata);
        int  cyc;
        logic g, rv;
        obs_timeout = 1'b0; obs_lat = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
        obs_other_rv = 1'b0; obs_both_gnt = 1'b0; obs_rdata = 32'h0; obs_err = 1'b0;
        acc1_addr = 32'h0; acc1_wdata = 32'h0; acc2_addr = 32'h0;
        acc1_rd = 1'b0; acc1_wr = 1'b0; acc2_rd = 1'b0; acc1_wbyte = 4'h0;
        @(posedge clk); #1;
        drive_port(port, 1'b1, we, addr, size, wdata);
        cyc = 0;
        g = 1'b0;
        while (!g && cyc < 8) begin
            @(negedge clk);
            g = (port == 0) ? p0_if.gnt : p1_if.gnt;
            if (p0_if.gnt && p1_if.gnt) obs_both_gnt = 1'b1;
            cyc++;
        end
        @(posedge clk); #1;
        drive_port(port, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        if (!g) begin
            obs_timeout = 1'b1;
            return;
        end
        rv = 1'b0;
        while (!rv && obs_lat < 8) begin
            @(negedge clk);
            obs_lat++;
            if (mem_rd_en) obs_rd_cnt++;
            if (mem_wr_en) obs_wr_cnt++;
            if (obs_lat == 1) begin
                acc1_addr = mem_addr; acc1_rd = mem_rd_en; acc1_wr = mem_wr_en;
                acc1_wbyte = mem_wbyte; acc1_wdata = mem_wdata;
            end
            if (obs_lat == 2) begin
                acc2_addr = mem_addr; acc2_rd = mem_rd_en;
            end
            rv = (port == 0) ? p0_if.rvalid : p1_if.rvalid;
            if ((port == 0) ? p1_if.rvalid : p0_if.rvalid) obs_other_rv = 1'b1;
        end
        if (!rv) obs_timeout = 1'b1;
        obs_rdata = (port == 0) ? p0_if.rdata : p1_if.rdata;
        obs_err   = (port == 0) ? p0_if.err   : p1_if.err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, p0_if.rvalid, p0_if.err, p1_if.gnt, p1_if.rvalid, p1_if.err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=000000",
                {p0_if.gnt, p0_if.rvalid, p0_if.err, p1_if.gnt, p1_if.rvalid, p1_if.err});
        end
        checks++;
        if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got=%h/%h want=0/0", p0_if.rdata, p1_if.rdata);
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wbyte, mem_wr_en, mem_rd_en} !== 70'h0) begin
            errors++; $display("FAIL reset_mem got addr=%h wdata=%h wbyte=%b wr=%b rd=%b want all 0",
                mem_addr, mem_wdata, mem_wbyte, mem_wr_en, mem_rd_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word_load();
        logic [31:0] er; logic ee; int el;
        preload_byte(8'h08, 8'h11); preload_byte(8'h09, 8'h22);
        preload_byte(8'h0A, 8'h33); preload_byte(8'h0B, 8'h44);
        ref_op(1'b0, 32'h8, 2'b10, 32'h0, er, ee, el);
        run_op(0, 1'b0, 32'h0000_0008, 2'b10, 32'h0);
        checks++;
        if (obs_timeout || obs_lat != 2) begin
            errors++; $display("FAIL word_load_latency got=%0d timeout=%b want=2", obs_lat, obs_timeout);
        end
        checks++;
        if (acc1_addr !== 32'h8 || acc1_rd !== 1'b1 || acc1_wr !== 1'b0) begin
            errors++; $display("FAIL word_load_access got addr=%h rd=%b wr=%b want addr=8 rd=1 wr=0",
                acc1_addr, acc1_rd, acc1_wr);
        end
        checks++;
        if (obs_rdata !== 32'h4433_2211 || obs_err !== 1'b0) begin
            errors++; $display("FAIL word_load_data got=%h err=%b want=44332211 err=0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] er; logic ee; int el;
        ref_op(1'b1, 32'h13, 2'b00, 32'hAB, er, ee, el);
        run_op(1, 1'b1, 32'h0000_0013, 2'b00, 32'h0000_00AB);
        checks++;
        if (acc1_addr !== 32'h10 || acc1_wbyte !== 4'b1000 || acc1_wdata[31:24] !== 8'hAB || acc1_wr !== 1'b1) begin
            errors++; $display("FAIL byte_store_access got addr=%h wbyte=%b lane3=%h wr=%b want 10/1000/ab/1",
                acc1_addr, acc1_wbyte, acc1_wdata[31:24], acc1_wr);
        end
        checks++;
        if (obs_timeout || obs_lat != 2 || obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_other_rv) begin
            errors++; $display("FAIL byte_store_resp got lat=%0d rdata=%h err=%b other_rv=%b want 2/0/0/0",
                obs_lat, obs_rdata, obs_err, obs_other_rv);
        end
    endtask

    task automatic test_alternation();
        int exp_owner, grants, last_cyc;
        bit bad_both, bad_order, bad_gap;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_port(0, 1'b1, 1'b0, 32'h20, 2'b10, 32'h0);
        drive_port(1, 1'b1, 1'b0, 32'h24, 2'b10, 32'h0);
        exp_owner = 0; grants = 0; last_cyc = -3;
        bad_both = 0; bad_order = 0; bad_gap = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (p0_if.gnt && p1_if.gnt) bad_both = 1;
            if (p0_if.gnt || p1_if.gnt) begin
                if ((p1_if.gnt ? 1 : 0) != exp_owner) bad_order = 1;
                if (c - last_cyc != 3) bad_gap = 1;
                last_cyc = c;
                exp_owner = 1 - exp_owner;
                grants++;
            end
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        repeat (4) @(posedge clk);
        checks++;
        if (bad_both) begin errors++; $display("FAIL alt_both_gnt got=1 want=0"); end
        checks++;
        if (bad_order) begin errors++; $display("FAIL alt_order got=non-alternating want=p0,p1,p0,..."); end
        checks++;
        if (bad_gap || grants != 12) begin
            errors++; $display("FAIL alt_rate got grants=%0d gap_bad=%0d want grants=12 gap=3", grants, bad_gap);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] er; logic ee; int el;
        logic [31:0] wd;
        preload_byte(8'h07, 8'hCD); preload_byte(8'h08, 8'hEF);
        ref_op(1'b0, 32'h7, 2'b01, 32'h0, er, ee, el);
        run_op(0, 1'b0, 32'h0000_0007, 2'b01, 32'h0);
        if (MIS_EN) begin
            checks++;
            if (obs_timeout || obs_lat != 3 || obs_rdata !== 32'h0000_EFCD || obs_err !== 1'b0) begin
                errors++; $display("FAIL mis_half_load got lat=%0d rdata=%h err=%b want 3/0000efcd/0",
                    obs_lat, obs_rdata, obs_err);
            end
            checks++;
            if (acc1_addr !== 32'h4 || !acc1_rd || acc2_addr !== 32'h8 || !acc2_rd) begin
                errors++; $display("FAIL mis_half_access got a1=%h rd1=%b a2=%h rd2=%b want 4/1/8/1",
                    acc1_addr, acc1_rd, acc2_addr, acc2_rd);
            end
        end else begin
            checks++;
            if (obs_timeout || obs_lat != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
                errors++; $display("FAIL mis_half_err got lat=%0d err=%b rdata=%h want 1/1/0",
                    obs_lat, obs_err, obs_rdata);
            end
            checks++;
            if (obs_rd_cnt != 0 || obs_wr_cnt != 0) begin
                errors++; $display("FAIL mis_half_strobes got rd=%0d wr=%0d want 0/0", obs_rd_cnt, obs_wr_cnt);
            end
        end
        // Word store straddling the top of the address space, then read it back
        wd = $urandom;
        ref_op(1'b1, 32'hFFFF_FFFE, 2'b10, wd, er, ee, el);
        run_op(1, 1'b1, 32'hFFFF_FFFE, 2'b10, wd);
        checks++;
        if (obs_timeout || obs_lat != el || obs_err !== ee || obs_wr_cnt != (ee ? 0 : 2)) begin
            errors++; $display("FAIL wrap_store got lat=%0d err=%b wr=%0d want %0d/%b/%0d",
                obs_lat, obs_err, obs_wr_cnt, el, ee, ee ? 0 : 2);
        end
        if (MIS_EN) begin
            checks++;
            if (acc1_addr !== 32'hFFFF_FFFC || acc2_addr !== 32'h0) begin
                errors++; $display("FAIL wrap_addr got a1=%h a2=%h want fffffffc/00000000", acc1_addr, acc2_addr);
            end
        end
        ref_op(1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0, er, ee, el);
        run_op(0, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0);
        checks++;
        if (obs_timeout || obs_rdata !== er || obs_err !== ee) begin
            errors++; $display("FAIL wrap_load got rdata=%h err=%b want %h/%b", obs_rdata, obs_err, er, ee);
        end
    endtask

    task automatic test_illegal_size();
        run_op(0, 1'b1, 32'h0000_0030, 2'b11, 32'hDEAD_BEEF);
        checks++;
        if (obs_timeout || obs_lat != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL illegal_resp got lat=%0d err=%b rdata=%h want 1/1/0",
                obs_lat, obs_err, obs_rdata);
        end
        checks++;
        if (obs_wr_cnt != 0 || obs_rd_cnt != 0) begin
            errors++; $display("FAIL illegal_strobes got wr=%0d rd=%0d want 0/0", obs_wr_cnt, obs_rd_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw_rv;
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 32'h8, 2'b10, 32'h0);
        @(negedge clk);
        checks++;
        if (p0_if.gnt !== 1'b1) begin errors++; $display("FAIL abort_grant got=%b want=1", p0_if.gnt); end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        saw_rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (p0_if.rvalid || p1_if.rvalid) saw_rv = 1;
        end
        checks++;
        if (saw_rv) begin errors++; $display("FAIL abort_rvalid got=1 want=0"); end
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 32'h8, 2'b10, 32'h0);
        drive_port(1, 1'b1, 1'b0, 32'hC, 2'b10, 32'h0);
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, p1_if.gnt} !== 2'b10) begin
            errors++; $display("FAIL post_reset_conflict got p0/p1=%b want=10", {p0_if.gnt, p1_if.gnt});
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_random();
        logic [31:0] er, addr, wd; logic ee; int el; int port; logic we; logic [1:0] size;
        for (int t = 0; t < 80; t++) begin
            port = $urandom_range(0, 1);
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            ref_op(we, addr, size, wd, er, ee, el);
            run_op(port, we, addr, size, wd);
            checks++;
            if (obs_timeout || obs_lat != el || obs_err !== ee || obs_rdata !== er || obs_other_rv || obs_both_gnt) begin
                errors++; $display("FAIL rand_op%0d p%0d we=%b a=%h sz=%0d got lat=%0d err=%b rdata=%h orv=%b want %0d/%b/%h/0",
                    t, port, we, addr, size, obs_lat, obs_err, obs_rdata, obs_other_rv, el, ee, er);
            end
            if (ee) begin
                checks++;
                if (obs_wr_cnt != 0 || obs_rd_cnt != 0) begin
                    errors++; $display("FAIL rand_err_strobes%0d got wr=%0d rd=%0d want 0/0", t, obs_wr_cnt, obs_rd_cnt);
                end
            end
        end
    endtask

    task automatic test_memory_image();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (mem[a] !== refmem[a]) begin
                errors++; $display("FAIL mem_image[%0d] got=%h want=%h", a, mem[a], refmem[a]);
            end
        end
    endtask

    initial begin
        pl_en = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
        test_reset();
        for (int a = 0; a < 256; a++) preload_byte(8'(a), 8'($urandom));
        test_word_load();
        test_byte_store();
        test_alternation();
        test_misaligned();
        test_illegal_size();
        test_reset_mid_op();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
